mapas_multissensor: RTL and testbench

//  Occupancy-grid builder: parametrised successor of mapas with rectangular grid, 2-bit heading and N range sensors.
//  Per accepted sample it marks robot cell VISITADO, traces each sensor ray, marks free cells LIVRE, hit cell OBSTACULO.

---
 rtl/mapas_multissensor_pkg.sv | 45 ++++
 rtl/mapas_multissensor_if.sv | 34 +++
 rtl/mapas_multissensor_passo_raio.sv | 42 ++++
 rtl/mapas_multissensor.sv | 145 ++++++++++++++
 tb/tb_mapas_multissensor.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mapas_multissensor_pkg.sv
`default_nettype none
// ============================================================================
// mapas_multissensor_pkg : cell codes, headings, FSM states and ray step helper
// Revision 1.0
// ============================================================================
package mapas_multissensor_pkg;

    typedef enum logic [1:0] {
        DESCONHECIDO = 2'b00,
        LIVRE        = 2'b01,
        OBSTACULO    = 2'b10,
        VISITADO     = 2'b11
    } celula_t;

    typedef enum logic [1:0] {
        MAIS_Y  = 2'd0,
        MAIS_X  = 2'd1,
        MENOS_Y = 2'd2,
        MENOS_X = 2'd3
    } direcao_t;

    typedef logic [2:0] estado_t;
    localparam estado_t OCIOSO   = 3'd0;
    localparam estado_t CAPTURA  = 3'd1;
    localparam estado_t TRACA    = 3'd2;
    localparam estado_t FINALIZA = 3'd3;
    localparam estado_t LIMPA    = 3'd4;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } passo_t;

    function automatic passo_t passo(input direcao_t dir);
        passo = '0;
        case (dir)
            MAIS_Y:  passo.dy = 2'b01;
            MAIS_X:  passo.dx = 2'b01;
            MENOS_Y: passo.dy = 2'b11;
            MENOS_X: passo.dx = 2'b11;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mapas_multissensor_if.sv
`default_nettype none
// ============================================================================
// mapas_multissensor_if : odometry/sensor sample in, occupancy grid out
// Revision 1.0
// ============================================================================
interface mapas_multissensor_if #(
    parameter int TamanhoMalhaX    = 9,
    parameter int TamanhoMalhaY    = 9,
    parameter int tamanhoDistancia = 4,
    parameter int NumSensores      = 2
);
    logic [tamanhoDistancia-1:0]             posicaoAtualnoEixoX;
    logic [tamanhoDistancia-1:0]             posicaoAtualnoEixoY;
    logic [1:0]                              direcaoAtual;
    logic [NumSensores*tamanhoDistancia-1:0] distancias;
    logic                                    novoDado;
    logic                                    limparMalha;
    logic                                    pronto;
    logic [TamanhoMalhaX*TamanhoMalhaY-1:0][1:0] malha;
    logic                                    operacaoFinalizada;

    modport master (
        output posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual, distancias,
               novoDado, limparMalha,
        input  pronto, malha, operacaoFinalizada
    );

    modport slave (
        input  posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual, distancias,
               novoDado, limparMalha,
        output pronto, malha, operacaoFinalizada
    );
endinterface
`default_nettype wire

// File: rtl/mapas_multissensor_passo_raio.sv
`default_nettype none
// ============================================================================
// mapas_multissensor_passo_raio : advances a ray one cell, flags grid membership
// Revision 1.0
// ============================================================================
module mapas_multissensor_passo_raio
    import mapas_multissensor_pkg::*;
#(
    parameter int TamanhoMalhaX    = 9,
    parameter int TamanhoMalhaY    = 9,
    parameter int tamanhoDistancia = 4
) (
    input  logic signed [tamanhoDistancia:0] x_i,
    input  logic signed [tamanhoDistancia:0] y_i,
    input  direcao_t                         dir_i,
    output logic signed [tamanhoDistancia:0] x_o,
    output logic signed [tamanhoDistancia:0] y_o,
    output logic                             dentro_o,
    output logic                             dentroSeguinte_o
);
    localparam int SW = tamanhoDistancia + 1;
    localparam logic signed [SW-1:0] LIM_X = SW'(TamanhoMalhaX);
    localparam logic signed [SW-1:0] LIM_Y = SW'(TamanhoMalhaY);

    passo_t                 w_p;
    logic signed [SW-1:0]   w_dx, w_dy, w_x2, w_y2;

    // Signed arithmetic: stepping below 0 or past the far edge shows up as
    // a negative value or a value >= the limit, never as a wrap into the grid.
    always_comb begin
        w_p  = passo(dir_i);
        w_dx = {{(SW-2){w_p.dx[1]}}, w_p.dx};
        w_dy = {{(SW-2){w_p.dy[1]}}, w_p.dy};
        x_o  = x_i + w_dx;
        y_o  = y_i + w_dy;
        w_x2 = x_o + w_dx;
        w_y2 = y_o + w_dy;
        dentro_o         = !x_o[SW-1] && (x_o < LIM_X) && !y_o[SW-1] && (y_o < LIM_Y);
        dentroSeguinte_o = !w_x2[SW-1] && (w_x2 < LIM_X) && !w_y2[SW-1] && (w_y2 < LIM_Y);
    end
endmodule
`default_nettype wire

// File: rtl/mapas_multissensor.sv
`default_nettype none
// ============================================================================
// mapas_multissensor : occupancy-grid builder with N range sensors
// Revision 1.0
// ============================================================================
module mapas_multissensor
    import mapas_multissensor_pkg::*;
#(
    parameter int TamanhoMalhaX    = 9,
    parameter int TamanhoMalhaY    = 9,
    parameter int tamanhoDistancia = 4,
    parameter int NumSensores      = 2,
    parameter int AlcanceMax       = 15
) (
    input logic                 clock,
    input logic                 reset,
    mapas_multissensor_if.slave bus
);
    localparam int TD     = tamanhoDistancia;
    localparam int NC     = TamanhoMalhaX * TamanhoMalhaY;
    localparam int IW     = $clog2(NC);
    localparam int CW     = (NumSensores > 1) ? $clog2(NumSensores) : 1;
    localparam int DESLOC = 4 / NumSensores;
    localparam logic [TD-1:0]        ALCANCE = TD'(AlcanceMax);
    localparam logic [CW-1:0]        ULTIMO  = CW'(NumSensores - 1);
    localparam logic signed [TD:0]   LIM_X   = (TD+1)'(TamanhoMalhaX);
    localparam logic signed [TD:0]   LIM_Y   = (TD+1)'(TamanhoMalhaY);

    estado_t                   estado_q, estado_d;
    logic [NC-1:0][1:0]        malha_q, malha_d;
    logic                      fin_q, fin_d;
    logic [TD-1:0]             x_q, x_d, y_q, y_d, passo_q, passo_d;
    direcao_t                  dir_q, dir_d;
    logic [NumSensores*TD-1:0] dist_q, dist_d;
    logic [CW-1:0]             canal_q, canal_d;
    logic signed [TD:0]        cx_q, cx_d, cy_q, cy_d;

    logic signed [TD:0] w_rx, w_ry, w_nx, w_ny;
    logic               w_dentro, w_dentro_seg, w_robo_dentro;
    logic               w_escreve, w_fim, w_permitido;
    direcao_t           w_dir_canal;
    logic [TD-1:0]      w_dist, w_lim;
    logic [IW-1:0]      w_idx_raio, w_idx_robo;
    celula_t            w_valor, w_atual;

    mapas_multissensor_passo_raio #(
        .TamanhoMalhaX   (TamanhoMalhaX),
        .TamanhoMalhaY   (TamanhoMalhaY),
        .tamanhoDistancia(TD)
    ) u_passo_raio (
        .x_i             (cx_q),
        .y_i             (cy_q),
        .dir_i           (w_dir_canal),
        .x_o             (w_nx),
        .y_o             (w_ny),
        .dentro_o        (w_dentro),
        .dentroSeguinte_o(w_dentro_seg)
    );

    always_comb begin
        w_rx          = {1'b0, x_q};
        w_ry          = {1'b0, y_q};
        w_robo_dentro = (w_rx < LIM_X) && (w_ry < LIM_Y);
        w_dir_canal   = direcao_t'(2'(int'(dir_q) + 1 + int'(canal_q) * DESLOC));
        w_dist        = '0;
        for (int i = 0; i < NumSensores; i++)
            if (canal_q == CW'(i)) w_dist = dist_q[i*TD +: TD];
        w_lim       = (w_dist > ALCANCE) ? ALCANCE : w_dist;
        w_escreve   = (estado_q == TRACA) && w_robo_dentro && (w_lim != '0) && w_dentro;
        // A channel ends on its last in-grid cell, so it costs max(1, n) cycles.
        w_fim       = !w_escreve || (passo_q == w_lim) || !w_dentro_seg;
        w_valor     = ((passo_q == w_dist) && (w_dist < ALCANCE)) ? OBSTACULO : LIVRE;
        w_idx_raio  = IW'(int'(w_nx[TD-1:0]) * TamanhoMalhaY + int'(w_ny[TD-1:0]));
        w_idx_robo  = IW'(int'(x_q) * TamanhoMalhaY + int'(y_q));
        w_atual     = celula_t'(malha_q[w_idx_raio]);
        w_permitido = (w_atual == DESCONHECIDO) || ((w_valor == OBSTACULO) && (w_atual == LIVRE));
    end

    always_comb begin
        estado_d = estado_q;  malha_d = malha_q;  fin_d   = fin_q;
        x_d      = x_q;       y_d     = y_q;      dir_d   = dir_q;   dist_d = dist_q;
        canal_d  = canal_q;   passo_d = passo_q;  cx_d    = cx_q;    cy_d   = cy_q;
        case (estado_q)
            OCIOSO: begin
                if (bus.limparMalha) begin
                    estado_d = LIMPA;
                    fin_d    = 1'b0;
                    malha_d  = '0;
                end else if (bus.novoDado) begin
                    estado_d = CAPTURA;
                    fin_d    = 1'b0;
                    x_d      = bus.posicaoAtualnoEixoX;
                    y_d      = bus.posicaoAtualnoEixoY;
                    dir_d    = direcao_t'(bus.direcaoAtual);
                    dist_d   = bus.distancias;
                end
            end
            CAPTURA: begin
                if (w_robo_dentro) malha_d[w_idx_robo] = VISITADO;
                canal_d  = '0;
                passo_d  = TD'(1);
                cx_d     = w_rx;
                cy_d     = w_ry;
                estado_d = TRACA;
            end
            TRACA: begin
                if (w_escreve && w_permitido) malha_d[w_idx_raio] = w_valor;
                if (!w_fim) begin
                    passo_d = passo_q + TD'(1);
                    cx_d    = w_nx;
                    cy_d    = w_ny;
                end else if (canal_q == ULTIMO) begin
                    estado_d = FINALIZA;
                end else begin
                    canal_d = canal_q + CW'(1);
                    passo_d = TD'(1);
                    cx_d    = w_rx;
                    cy_d    = w_ry;
                end
            end
            FINALIZA, LIMPA: begin
                fin_d    = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= OCIOSO;  malha_q <= '0;  fin_q   <= 1'b0;
            x_q      <= '0;      y_q     <= '0;  dir_q   <= MAIS_Y;  dist_q <= '0;
            canal_q  <= '0;      passo_q <= '0;  cx_q    <= '0;      cy_q   <= '0;
        end else begin
            estado_q <= estado_d;  malha_q <= malha_d;  fin_q   <= fin_d;
            x_q      <= x_d;       y_q     <= y_d;      dir_q   <= dir_d;  dist_q <= dist_d;
            canal_q  <= canal_d;   passo_q <= passo_d;  cx_q    <= cx_d;   cy_q   <= cy_d;
        end
    end

    assign bus.pronto             = (estado_q == OCIOSO);
    assign bus.malha              = malha_q;
    assign bus.operacaoFinalizada = fin_q;
endmodule
`default_nettype wire

// File: tb/tb_mapas_multissensor.sv
`default_nettype none
// ============================================================================
// tb_mapas_multissensor : directed vector table plus corner-case sequences
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mapas_multissensor;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mapas_multissensor_if #(.TamanhoMalhaX(9), .TamanhoMalhaY(9), .tamanhoDistancia(4), .NumSensores(2)) ifa ();
    mapas_multissensor_if #(.TamanhoMalhaX(6), .TamanhoMalhaY(4), .tamanhoDistancia(4), .NumSensores(4)) ifb ();

    mapas_multissensor #(.TamanhoMalhaX(9), .TamanhoMalhaY(9), .tamanhoDistancia(4),
                         .NumSensores(2), .AlcanceMax(15))
        dut_a (.clock(clk), .reset(rst_n), .bus(ifa.slave));
    mapas_multissensor #(.TamanhoMalhaX(6), .TamanhoMalhaY(4), .tamanhoDistancia(4),
                         .NumSensores(4), .AlcanceMax(15))
        dut_b (.clock(clk), .reset(rst_n), .bus(ifb.slave));

    typedef struct packed {
        logic [3:0]       x, y;
        logic [1:0]       dir;
        logic [3:0]       d0, d1;
        logic             clr;
        logic [7:0]       lat;
        logic [3:0]       nmod;
        logic [7:0][3:0]  mx;
        logic [7:0][3:0]  my;
        logic [7:0][1:0]  mv;
    } vec_t;

    vec_t             tab [6];
    logic [80:0][1:0] exp_a = '0;
    logic [23:0][1:0] exp_b = '0;
    int               lat;

    task automatic chk(input string nome, input logic [255:0] atual, input logic [255:0] esperado);
        n_vec++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    function automatic vec_t mk(int x, int y, int dir, int d0, int d1, int clr, int l);
        mk     = '0;
        mk.x   = 4'(x);   mk.y  = 4'(y);  mk.dir = 2'(dir);
        mk.d0  = 4'(d0);  mk.d1 = 4'(d1); mk.clr = 1'(clr);
        mk.lat = 8'(l);
    endfunction

    task automatic add(input int i, input int x, input int y, input int v);
        tab[i].mx[tab[i].nmod] = 4'(x);
        tab[i].my[tab[i].nmod] = 4'(y);
        tab[i].mv[tab[i].nmod] = 2'(v);
        tab[i].nmod            = tab[i].nmod + 4'd1;
    endtask

    task automatic amostra_a(input logic [3:0] x, input logic [3:0] y, input logic [1:0] dir,
                             input logic [3:0] d0, input logic [3:0] d1, output int l);
        @(negedge clk);
        ifa.posicaoAtualnoEixoX = x;
        ifa.posicaoAtualnoEixoY = y;
        ifa.direcaoAtual        = dir;
        ifa.distancias          = {d1, d0};
        ifa.novoDado            = 1'b1;
        @(negedge clk);
        ifa.novoDado = 1'b0;
        chk("a_pronto_cai", 256'(ifa.pronto), 256'(0));
        l = 0;
        while (!ifa.operacaoFinalizada && l < 60) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic amostra_b(input logic [3:0] x, input logic [3:0] y, input logic [15:0] d, output int l);
        @(negedge clk);
        ifb.posicaoAtualnoEixoX = x;
        ifb.posicaoAtualnoEixoY = y;
        ifb.direcaoAtual        = 2'd0;
        ifb.distancias          = d;
        ifb.novoDado            = 1'b1;
        @(negedge clk);
        ifb.novoDado = 1'b0;
        chk("b_pronto_cai", 256'(ifb.pronto), 256'(0));
        l = 0;
        while (!ifb.operacaoFinalizada && l < 60) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic limpa_a();
        @(negedge clk);
        ifa.limparMalha = 1'b1;
        @(negedge clk);
        ifa.limparMalha = 1'b0;
        @(negedge clk);
        exp_a = '0;
        chk("a_limpa_fin", 256'(ifa.operacaoFinalizada), 256'(1));
        chk("a_limpa_malha", 256'(ifa.malha), 256'(exp_a));
    endtask

    initial begin
        ifa.posicaoAtualnoEixoX = '0; ifa.posicaoAtualnoEixoY = '0; ifa.direcaoAtual = '0;
        ifa.distancias = '0; ifa.novoDado = 1'b0; ifa.limparMalha = 1'b0;
        ifb.posicaoAtualnoEixoX = '0; ifb.posicaoAtualnoEixoY = '0; ifb.direcaoAtual = '0;
        ifb.distancias = '0; ifb.novoDado = 1'b0; ifb.limparMalha = 1'b0;

        repeat (3) @(negedge clk);
        chk("a_reset_pronto", 256'(ifa.pronto), 256'(1));
        chk("a_reset_fin", 256'(ifa.operacaoFinalizada), 256'(0));
        chk("a_reset_malha", 256'(ifa.malha), 256'(0));
        chk("b_reset_pronto", 256'(ifb.pronto), 256'(1));
        rst_n = 1'b1;

        tab[0] = mk(2, 0, 0, 3, 2, 0, 7);
        add(0, 2, 0, 3); add(0, 3, 0, 1); add(0, 4, 0, 1); add(0, 5, 0, 2); add(0, 1, 0, 1); add(0, 0, 0, 2);
        // LIVRE must not touch (5,0)=10 or (2,0)=11; OBSTACULO lands on (1,0)=01
        tab[1] = mk(6, 0, 0, 1, 5, 0, 8);
        add(1, 6, 0, 3); add(1, 7, 0, 2); add(1, 1, 0, 2);
        tab[2] = mk(2, 0, 0, 3, 5, 1, 7);
        add(2, 2, 0, 3); add(2, 3, 0, 1); add(2, 4, 0, 1); add(2, 5, 0, 2); add(2, 1, 0, 1); add(2, 0, 0, 1);
        tab[3] = mk(0, 4, 1, 15, 0, 1, 7);
        add(3, 0, 4, 3); add(3, 0, 3, 1); add(3, 0, 2, 1); add(3, 0, 1, 1); add(3, 0, 0, 1);
        tab[4] = mk(8, 8, 2, 2, 4, 0, 5);
        add(4, 8, 8, 3); add(4, 7, 8, 1); add(4, 6, 8, 2);
        tab[5] = mk(4, 4, 3, 15, 1, 0, 7);
        add(5, 4, 4, 3); add(5, 4, 5, 1); add(5, 4, 6, 1); add(5, 4, 7, 1); add(5, 4, 8, 1); add(5, 4, 3, 2);

        for (int i = 0; i < 6; i++) begin
            if (tab[i].clr) limpa_a();
            amostra_a(tab[i].x, tab[i].y, tab[i].dir, tab[i].d0, tab[i].d1, lat);
            for (int k = 0; k < int'(tab[i].nmod); k++)
                exp_a[int'(tab[i].mx[k]) * 9 + int'(tab[i].my[k])] = tab[i].mv[k];
            chk($sformatf("a_lat_v%0d", i), 256'(lat), 256'(tab[i].lat));
            chk($sformatf("a_malha_v%0d", i), 256'(ifa.malha), 256'(exp_a));
        end

        // limparMalha together with novoDado: only the clear happens
        @(negedge clk);
        ifa.posicaoAtualnoEixoX = 4'd3; ifa.posicaoAtualnoEixoY = 4'd3;
        ifa.direcaoAtual = 2'd0; ifa.distancias = {4'd2, 4'd2};
        ifa.novoDado = 1'b1; ifa.limparMalha = 1'b1;
        @(negedge clk);
        ifa.novoDado = 1'b0; ifa.limparMalha = 1'b0;
        chk("a_limpa_novo_pronto", 256'(ifa.pronto), 256'(0));
        @(negedge clk);
        exp_a = '0;
        chk("a_limpa_novo_fin", 256'(ifa.operacaoFinalizada), 256'(1));
        chk("a_limpa_novo_pronto2", 256'(ifa.pronto), 256'(1));
        chk("a_limpa_novo_malha", 256'(ifa.malha), 256'(exp_a));
        @(negedge clk);
        chk("a_limpa_estavel", 256'(ifa.malha), 256'(exp_a));

        // Reset asserted while rays are still being traced
        @(negedge clk);
        ifa.posicaoAtualnoEixoX = 4'd2; ifa.posicaoAtualnoEixoY = 4'd0;
        ifa.direcaoAtual = 2'd0; ifa.distancias = {4'd2, 4'd3};
        ifa.novoDado = 1'b1;
        @(negedge clk);
        ifa.novoDado = 1'b0;
        repeat (3) @(negedge clk);
        exp_a[2*9+0] = 2'b11; exp_a[3*9+0] = 2'b01; exp_a[4*9+0] = 2'b01;
        chk("a_meio_traca", 256'(ifa.malha), 256'(exp_a));
        rst_n = 1'b0;
        @(negedge clk);
        exp_a = '0;
        chk("a_rst_meio_malha", 256'(ifa.malha), 256'(exp_a));
        chk("a_rst_meio_pronto", 256'(ifa.pronto), 256'(1));
        chk("a_rst_meio_fin", 256'(ifa.operacaoFinalizada), 256'(0));
        rst_n = 1'b1;

        // 6x4 grid, 4 sensors: robot outside the grid changes nothing
        amostra_b(4'd7, 4'd1, {4'd3, 4'd3, 4'd3, 4'd3}, lat);
        chk("b_fora_lat", 256'(lat), 256'(6));
        chk("b_fora_malha", 256'(ifb.malha), 256'(exp_b));

        // Robot (1,1) heading +Y: rays +X d=2, -Y d=3, -X d=1, +Y d=15
        amostra_b(4'd1, 4'd1, {4'd15, 4'd1, 4'd3, 4'd2}, lat);
        exp_b[5] = 2'b11; exp_b[9] = 2'b01; exp_b[13] = 2'b10; exp_b[4] = 2'b01;
        exp_b[1] = 2'b10; exp_b[6] = 2'b01; exp_b[7] = 2'b01;
        chk("b_dentro_lat", 256'(lat), 256'(8));
        chk("b_dentro_malha", 256'(ifb.malha), 256'(exp_b));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
